// File: rtl/minibyte_pkg.sv
// Shared encodings for the minibyte_core_p accumulator CPU: opcodes, sequencer states, ALU ops.
// Opcode decode helpers live here so the core stays a pure sequencer.
package minibyte_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LDM  = 4'h2;
    localparam logic [3:0] OP_STM  = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_ADDM = 4'h5;
    localparam logic [3:0] OP_SUBI = 4'h6;
    localparam logic [3:0] OP_SUBM = 4'h7;
    localparam logic [3:0] OP_ANDI = 4'h8;
    localparam logic [3:0] OP_ORI  = 4'h9;
    localparam logic [3:0] OP_XORI = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_JN   = 4'hD;
    localparam logic [3:0] OP_JC   = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_OPERAND = 2'd1,
        ST_MEM     = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        ALU_PASS_B = 3'd0,
        ALU_ADD    = 3'd1,
        ALU_SUB    = 3'd2,
        ALU_AND    = 3'd3,
        ALU_OR     = 3'd4,
        ALU_XOR    = 3'd5
    } alu_op_t;

    function automatic alu_op_t alu_op_for(input logic [3:0] op);
        case (op)
            OP_ADDI, OP_ADDM: return ALU_ADD;
            OP_SUBI, OP_SUBM: return ALU_SUB;
            OP_ANDI:          return ALU_AND;
            OP_ORI:           return ALU_OR;
            OP_XORI:          return ALU_XOR;
            default:          return ALU_PASS_B;
        endcase
    endfunction

    function automatic logic is_imm_op(input logic [3:0] op);
        return op inside {OP_LDI, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI};
    endfunction

    function automatic logic is_mem_op(input logic [3:0] op);
        return op inside {OP_LDM, OP_ADDM, OP_SUBM, OP_STM};
    endfunction

endpackage

// File: rtl/minibyte_alu_p.sv
// Combinational ALU for minibyte_core_p: result plus zero/negative/carry.
// Carry is the carry-out for ADD, the unsigned borrow for SUB, and 0 otherwise.
module minibyte_alu_p
    import minibyte_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  alu_op_t           i_op,
    output logic [DATA_W-1:0] o_result,
    output logic              o_z,
    output logic              o_n,
    output logic              o_carry
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_result = i_b;
        o_carry  = 1'b0;
        case (i_op)
            ALU_ADD: {o_carry, o_result} = w_sum;
            ALU_SUB: {o_carry, o_result} = w_diff;
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_XOR: o_result = i_a ^ i_b;
            default: o_result = i_b;
        endcase
        o_z = (o_result == '0);
        o_n = o_result[DATA_W-1];
    end

endmodule

// File: rtl/minibyte_core_p.sv
// minibyte_core_p: parametrised accumulator CPU with FETCH/OPERAND/MEM sequencer.
// Optional carry flag and JC opcode enabled by defining MINIBYTE_CARRY_EN.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_FETCH   | read opcode at PC, latch IR, PC+1
//   ST_OPERAND | read operand at PC: immediate ALU op, jump, or latch M
//   ST_MEM     | access word at M: load/arith into A, or STM write strobe
//   ST_HALT    | frozen until reset
module minibyte_core_p
    import minibyte_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              we_out,
    output logic              halt_out
);

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_m;
    logic [DATA_W-1:0]   r_a;
    logic [3:0]          r_ir;
    logic                r_z;
    logic                r_n;
`ifdef MINIBYTE_CARRY_EN
    logic                r_c;
`endif

    logic [DATA_W-1:0]   w_alu_res;
    logic                w_alu_z;
    logic                w_alu_n;
    logic                w_alu_c;
    alu_op_t             w_alu_op;
    logic                w_a_we;
    logic                w_jump_taken;

    assign w_alu_op = alu_op_for(r_ir);

    minibyte_alu_p #(.DATA_W(DATA_W)) u_alu (
        .i_a      (r_a),
        .i_b      (data_in),
        .i_op     (w_alu_op),
        .o_result (w_alu_res),
        .o_z      (w_alu_z),
        .o_n      (w_alu_n),
        .o_carry  (w_alu_c)
    );

`ifndef MINIBYTE_CARRY_EN
    logic w_unused_carry;
    assign w_unused_carry = w_alu_c;
`endif

    assign w_a_we = ((r_state == ST_OPERAND) && is_imm_op(r_ir))
                 || ((r_state == ST_MEM) && (r_ir != OP_STM));

    always_comb begin
        w_jump_taken = 1'b0;
        case (r_ir)
            OP_JMP:  w_jump_taken = 1'b1;
            OP_JZ:   w_jump_taken = r_z;
            OP_JN:   w_jump_taken = r_n;
`ifdef MINIBYTE_CARRY_EN
            OP_JC:   w_jump_taken = r_c;
`endif
            default: w_jump_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_FETCH;
            r_pc    <= PC_RST;
            r_m     <= '0;
            r_a     <= '0;
            r_ir    <= '0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
`ifdef MINIBYTE_CARRY_EN
            r_c     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_FETCH: begin
                    r_ir <= data_in[3:0];
                    r_pc <= r_pc + 1'b1;
                    case (data_in[3:0])
                        OP_NOP: r_state <= ST_FETCH;
                        OP_HLT: r_state <= ST_HALT;
`ifdef MINIBYTE_CARRY_EN
                        OP_JC:  r_state <= ST_OPERAND;
`else
                        OP_JC:  r_state <= ST_FETCH;
`endif
                        default: r_state <= ST_OPERAND;
                    endcase
                end
                ST_OPERAND: begin
                    r_pc <= w_jump_taken ? data_in[ADDR_W-1:0] : r_pc + 1'b1;
                    if (is_mem_op(r_ir)) begin
                        r_m     <= data_in[ADDR_W-1:0];
                        r_state <= ST_MEM;
                    end else begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_MEM:  r_state <= ST_FETCH;
                default: r_state <= ST_HALT;
            endcase

            if (w_a_we) begin
                r_a <= w_alu_res;
                r_z <= w_alu_z;
                r_n <= w_alu_n;
`ifdef MINIBYTE_CARRY_EN
                // Plain loads leave C alone; arithmetic and logic ops own it.
                if (w_alu_op != ALU_PASS_B)
                    r_c <= w_alu_c;
`endif
            end
        end
    end

    // A reset arriving during the STM cycle suppresses the strobe immediately.
    assign we_out   = (r_state == ST_MEM) && (r_ir == OP_STM) && !rst_in;
    assign addr_out = (r_state == ST_MEM) ? r_m : r_pc;
    assign data_out = r_a;
    assign halt_out = (r_state == ST_HALT);

endmodule

// File: tb/tb_minibyte_core_p.sv
// Self-checking bench for minibyte_core_p: default 8-bit instance plus a 12/10-bit
// instance with RESET_PC at the top of the address space.
module tb_minibyte_core_p;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [7:0]  d0;
    logic [7:0]  a0;
    logic [7:0]  q0;
    logic        we0;
    logic        h0;
    logic [7:0]  mem0 [0:255];

    logic [11:0] d1;
    logic [9:0]  a1;
    logic [11:0] q1;
    logic        we1;
    logic        h1;
    logic [11:0] mem1 [0:1023];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign d0 = mem0[a0];
    assign d1 = mem1[a1];

    minibyte_core_p dut0 (
        .clk_in  (clk),
        .rst_in  (rst),
        .data_in (d0),
        .addr_out(a0),
        .data_out(q0),
        .we_out  (we0),
        .halt_out(h0)
    );

    minibyte_core_p #(.DATA_W(12), .ADDR_W(10), .RESET_PC(10'h3FF)) dut1 (
        .clk_in  (clk),
        .rst_in  (rst),
        .data_in (d1),
        .addr_out(a1),
        .data_out(q1),
        .we_out  (we1),
        .halt_out(h1)
    );

    typedef struct {
        logic [3:0] op;
        logic [7:0] a_init;
        logic [7:0] imm;
        logic [7:0] exp_a;
        logic       exp_z;
        logic       exp_n;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_mem0();
        for (int i = 0; i < 256; i++) mem0[i] = 8'h00;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int  wcount;
        logic ok;

        vecs[0] = '{4'h4, 8'h05, 8'hFE, 8'h03, 1'b0, 1'b0};
        vecs[1] = '{4'h4, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{4'h4, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{4'h6, 8'h03, 8'h03, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{4'h6, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1};
        vecs[5] = '{4'h8, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{4'h9, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b1};
        vecs[7] = '{4'hA, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0};
        vecs[8] = '{4'h1, 8'h12, 8'h80, 8'h80, 1'b0, 1'b1};

        for (int i = 0; i < 1024; i++) mem1[i] = 12'h000;
        mem1[10'h3FF] = 12'h001;
        mem1[10'h000] = 12'h001;
        mem1[10'h001] = 12'h004;
        mem1[10'h002] = 12'hFFF;
        mem1[10'h003] = 12'h00E;
        mem1[10'h004] = 12'h010;

        // Reset state and NOP stream
        clear_mem0();
        do_reset();
        check("rst_addr", 32'(a0), 32'h00);
        check("rst_data", 32'(q0), 32'h00);
        check("rst_we", 32'(we0), 32'h0);
        check("rst_halt", 32'(h0), 32'h0);
        check("rst_z", 32'(dut0.r_z), 32'h0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check($sformatf("nop_addr%0d", c), 32'(a0), 32'(c));
            check($sformatf("nop_we%0d", c), 32'(we0), 32'h0);
        end

        // Table-driven: LDI a_init ; <op> imm
        for (int v = 0; v < 9; v++) begin
            clear_mem0();
            mem0[0] = 8'h01;
            mem0[1] = vecs[v].a_init;
            mem0[2] = {4'h0, vecs[v].op};
            mem0[3] = vecs[v].imm;
            do_reset();
            repeat (4) tick();
            check($sformatf("vec%0d_a", v), 32'(q0), 32'(vecs[v].exp_a));
            check($sformatf("vec%0d_z", v), 32'(dut0.r_z), 32'(vecs[v].exp_z));
            check($sformatf("vec%0d_n", v), 32'(dut0.r_n), 32'(vecs[v].exp_n));
            check($sformatf("vec%0d_pc", v), 32'(a0), 32'h04);
        end

        // Memory path: LDM 40 ; ADDM 40 ; STM 41
        clear_mem0();
        mem0[8'h40] = 8'h7F;
        mem0[0] = 8'h02; mem0[1] = 8'h40;
        mem0[2] = 8'h05; mem0[3] = 8'h40;
        mem0[4] = 8'h03; mem0[5] = 8'h41;
        do_reset();
        wcount = 0;
        for (int c = 0; c < 12; c++) begin
            if (we0) wcount++;
            if (c == 8) begin
                check("stm_addr", 32'(a0), 32'h41);
                check("stm_data", 32'(q0), 32'hFE);
                check("stm_we", 32'(we0), 32'h1);
                check("stm_n", 32'(dut0.r_n), 32'h1);
            end
            tick();
        end
        check("stm_we_count", 32'(wcount), 32'd1);

        // Branches: LDI 0 ; JZ 20 ; @20 JN 00 (not taken) ; JMP 00
        clear_mem0();
        mem0[0] = 8'h01; mem0[1] = 8'h00;
        mem0[2] = 8'h0C; mem0[3] = 8'h20;
        mem0[8'h20] = 8'h0D; mem0[8'h21] = 8'h00;
        mem0[8'h22] = 8'h0B; mem0[8'h23] = 8'h00;
        do_reset();
        repeat (4) tick();
        check("jz_taken", 32'(a0), 32'h20);
        repeat (2) tick();
        check("jn_fall", 32'(a0), 32'h22);
        repeat (2) tick();
        check("jmp_taken", 32'(a0), 32'h00);

        // Halt holds for 10 cycles
        clear_mem0();
        mem0[0] = 8'h0F;
        do_reset();
        tick();
        check("halt_on", 32'(h0), 32'h1);
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (h0 !== 1'b1 || a0 !== 8'h01 || we0 !== 1'b0) ok = 1'b0;
        end
        check("halt_frozen", 32'(ok), 32'h1);

        // Reset during OPERAND, then during the STM MEM cycle
        clear_mem0();
        mem0[0] = 8'h01; mem0[1] = 8'h33;
        mem0[2] = 8'h03; mem0[3] = 8'h50;
        do_reset();
        repeat (3) tick();
        check("mid_operand_addr", 32'(a0), 32'h03);
        rst = 1'b1;
        tick();
        check("mid_rst_pc", 32'(a0), 32'h00);
        check("mid_rst_a", 32'(q0), 32'h00);
        check("mid_rst_we", 32'(we0), 32'h0);
        check("mid_rst_halt", 32'(h0), 32'h0);
        rst = 1'b0;
        repeat (4) tick();
        check("mem_cycle_we", 32'(we0), 32'h1);
        check("mem_cycle_addr", 32'(a0), 32'h50);
        check("mem_cycle_data", 32'(q0), 32'h33);
        rst = 1'b1;
        #1;
        check("mem_rst_we_gated", 32'(we0), 32'h0);
        tick();
        rst = 1'b0;
        check("mem_rst_a", 32'(q0), 32'h00);
        check("mem_rst_pc", 32'(a0), 32'h00);

        // Wide instance: PC wrap, ADD overflow to zero, JC / E-as-NOP
        do_reset();
        check("w_first_fetch", 32'(a1), 32'h3FF);
        tick();
        check("w_wrap", 32'(a1), 32'h000);
        repeat (3) tick();
        check("w_add_a", 32'(q1), 32'h000);
        check("w_add_z", 32'(dut1.r_z), 32'h1);
        check("w_add_n", 32'(dut1.r_n), 32'h0);
        repeat (2) tick();
`ifdef MINIBYTE_CARRY_EN
        check("w_carry", 32'(dut1.r_c), 32'h1);
        check("w_jc_taken", 32'(a1), 32'h010);
`else
        check("w_e_nop", 32'(a1), 32'h005);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
